// File: rtl/tp_pkg.sv
// Shared types and constants for the TeamPlayer multitap nibble sequencer.
package tp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_TYPES,
    ST_PADS,
    ST_END
  } tp_state_e;

  typedef enum logic [1:0] {
    PT_NONE     = 2'd0,
    PT_3BTN     = 2'd1,
    PT_6BTN     = 2'd2,
    PT_NONE_ALT = 2'd3
  } tp_pad_type_e;

  localparam int MAX_PADS = 4;
  localparam int BTN_W    = 12;
  localparam int SNAP_W   = MAX_PADS * BTN_W;

  localparam logic [3:0] NIB_IDLE     = 4'h3;
  localparam logic [3:0] NIB_HDR0     = 4'h3;
  localparam logic [3:0] NIB_HDR1     = 4'hF;
  localparam logic [3:0] NIB_HDR2     = 4'h0;
  localparam logic [3:0] NIB_HDR3     = 4'h0;
  localparam logic [3:0] NIB_END      = 4'hF;
  localparam logic [3:0] NIB_TYPE_3B  = 4'h0;
  localparam logic [3:0] NIB_TYPE_6B  = 4'h1;
  localparam logic [3:0] NIB_TYPE_NONE = 4'hF;

  localparam logic [4:0] IDX_TYPES = 5'd4;
  localparam logic [4:0] IDX_PADS  = 5'd8;
  localparam logic [4:0] IDX_MAX   = 5'd31;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_MODE  = 8;
  localparam int BTN_X     = 9;
  localparam int BTN_Y     = 10;
  localparam int BTN_Z     = 11;

  function automatic logic [4:0] pad_nibbles(input logic [1:0] t);
    case (tp_pad_type_e'(t))
      PT_3BTN: return 5'd2;
      PT_6BTN: return 5'd3;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [3:0] type_nib(input logic [1:0] t);
    case (tp_pad_type_e'(t))
      PT_3BTN: return NIB_TYPE_3B;
      PT_6BTN: return NIB_TYPE_6B;
      default: return NIB_TYPE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tp_nibble_sel.sv
// Combinational pick of one active-low button nibble from the latched pad snapshot.
module tp_nibble_sel
  import tp_pkg::*;
(
  input  logic [SNAP_W-1:0] i_btn_snap,
  input  logic [1:0]        i_slot,
  input  logic [1:0]        i_nib,
  output logic [3:0]        o_data
);

  logic [BTN_W-1:0] w_btn;

  assign w_btn = i_btn_snap[i_slot*BTN_W +: BTN_W];

  always_comb begin
    o_data = NIB_END;
    case (i_nib)
      2'd0:    o_data = ~{w_btn[BTN_RIGHT], w_btn[BTN_LEFT], w_btn[BTN_DOWN], w_btn[BTN_UP]};
      2'd1:    o_data = ~{w_btn[BTN_START], w_btn[BTN_A], w_btn[BTN_C], w_btn[BTN_B]};
      2'd2:    o_data = ~{w_btn[BTN_MODE], w_btn[BTN_X], w_btn[BTN_Y], w_btn[BTN_Z]};
      default: o_data = NIB_END;
    endcase
  end

endmodule

// File: rtl/teamplayer_n.sv
// TeamPlayer multitap sequencer: TH/TR handshake walks header, type and pad nibbles.
// Optional inactivity watchdog enabled by defining TEAMPLAYER_WATCHDOG_EN.
module teamplayer_n
  import tp_pkg::*;
#(
  parameter int NUM_PADS   = 4,
  parameter int TIMEOUT_CE = 2048
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      CE,
  input  logic                      TH,
  input  logic                      TR,
  input  logic [NUM_PADS*BTN_W-1:0] PAD_BTN,
  input  logic [NUM_PADS*2-1:0]     PAD_TYPE,
  output logic [3:0]                DATA,
  output logic                      TL
);

  tp_state_e         r_state;
  logic [4:0]        r_idx;
  logic              r_tl;
  logic              r_th_q;
  logic              r_tr_q;
  logic [SNAP_W-1:0] r_btn_snap;
  logic [7:0]        r_type_snap;

  tp_state_e         w_state_nxt;
  logic [4:0]        w_idx_nxt;
  logic              w_tl_nxt;
  logic              w_load;
  logic              w_th_fall;
  logic              w_th_chg;
  logic              w_tr_chg;
  logic              w_wd_expire;
  logic [4:0]        w_total;
  logic [4:0]        w_off;
  logic [1:0]        w_slot;
  logic [1:0]        w_nib;
  logic [3:0]        w_pad_nib;
  logic [SNAP_W-1:0] w_btn_ext;
  logic [7:0]        w_type_ext;

  // Unused slots zero-extend to type 0, which reads as "none".
  assign w_btn_ext  = SNAP_W'(PAD_BTN);
  assign w_type_ext = 8'(PAD_TYPE);

  assign w_th_fall = r_th_q & ~TH;
  assign w_th_chg  = TH != r_th_q;
  assign w_tr_chg  = TR != r_tr_q;
  assign TL        = r_tl;

`ifdef TEAMPLAYER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CE + 1);

  logic [WD_W-1:0] r_wd_cnt;

  assign w_wd_expire = (r_state != ST_IDLE) && !w_th_chg && !w_tr_chg &&
                       (r_wd_cnt == WD_W'(TIMEOUT_CE - 1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wd_cnt <= '0;
    end else if (CE) begin
      if (w_th_chg || w_tr_chg || (r_state == ST_IDLE) || w_wd_expire)
        r_wd_cnt <= '0;
      else
        r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end
`else
  assign w_wd_expire = 1'b0;
`endif

  always_comb begin
    w_total = '0;
    for (int s = 0; s < MAX_PADS; s++)
      w_total = w_total + pad_nibbles(r_type_snap[2*s +: 2]);
  end

  // Pads vary in length, so locate the slot by walking cumulative nibble counts.
  always_comb begin
    logic [4:0] acc;
    logic [4:0] cnt;
    w_off  = r_idx - IDX_PADS;
    w_slot = '0;
    w_nib  = '0;
    acc    = '0;
    for (int s = 0; s < MAX_PADS; s++) begin
      cnt = pad_nibbles(r_type_snap[2*s +: 2]);
      if ((w_off >= acc) && (w_off < acc + cnt)) begin
        w_slot = 2'(s);
        w_nib  = 2'(w_off - acc);
      end
      acc = acc + cnt;
    end
  end

  tp_nibble_sel u_nibble_sel (
    .i_btn_snap (r_btn_snap),
    .i_slot     (w_slot),
    .i_nib      (w_nib),
    .o_data     (w_pad_nib)
  );

  always_comb begin
    DATA = NIB_IDLE;
    case (r_state)
      ST_IDLE: DATA = NIB_IDLE;
      ST_HDR: begin
        case (r_idx[1:0])
          2'd0:    DATA = NIB_HDR0;
          2'd1:    DATA = NIB_HDR1;
          2'd2:    DATA = NIB_HDR2;
          default: DATA = NIB_HDR3;
        endcase
      end
      ST_TYPES: DATA = type_nib(r_type_snap[2*r_idx[1:0] +: 2]);
      ST_PADS:  DATA = w_pad_nib;
      ST_END:   DATA = NIB_END;
      default:  DATA = NIB_IDLE;
    endcase
  end

  // TH high wins over everything, including a TR edge on the same tick.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_tl_nxt    = r_tl;
    w_load      = 1'b0;
    if (TH) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_tl_nxt    = 1'b1;
    end else if (w_th_fall) begin
      w_state_nxt = ST_HDR;
      w_idx_nxt   = '0;
      w_tl_nxt    = TR;
      w_load      = 1'b1;
    end else if ((r_state != ST_IDLE) && w_tr_chg) begin
      w_tl_nxt = TR;
      if (r_idx != IDX_MAX)
        w_idx_nxt = r_idx + 1'b1;
      if (r_state == ST_END)
        w_state_nxt = ST_END;
      else if (w_idx_nxt < IDX_TYPES)
        w_state_nxt = ST_HDR;
      else if (w_idx_nxt < IDX_PADS)
        w_state_nxt = ST_TYPES;
      else if (w_idx_nxt < IDX_PADS + w_total)
        w_state_nxt = ST_PADS;
      else
        w_state_nxt = ST_END;
    end else if (w_wd_expire) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_tl_nxt    = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_tl        <= 1'b1;
      r_th_q      <= 1'b0;
      r_tr_q      <= 1'b1;
      r_btn_snap  <= '0;
      r_type_snap <= '0;
    end else if (CE) begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_tl    <= w_tl_nxt;
      r_th_q  <= TH;
      r_tr_q  <= TR;
      if (w_load) begin
        r_btn_snap  <= w_btn_ext;
        r_type_snap <= w_type_ext;
      end
    end
  end

endmodule

// File: doc/teamplayer_n.md
TEAMPLAYER_N -- requirements
Module: teamplayer_n

Interface
REQ-001 Parameter NUM_PADS, default 4: number of pad slots served, legal range 1..4.
REQ-002 Parameter TIMEOUT_CE, default 2048: CE ticks of TH/TR inactivity before the watchdog returns to IDLE.
REQ-003 CLK  input  1  system clock; one clock; reset is asynchronous and active-low (RESET_N).
REQ-004 RESET_N  input  1  asynchronous active-low reset.
REQ-005 CE  input  1  sampling enable; all state advances only on CLK edges with CE=1.
REQ-006 TH  input  1  resolved port TH line (host-driven select).
REQ-007 TR  input  1  resolved port TR line (host-driven request/toggle).
REQ-008 PAD_BTN  input  NUM_PADS*12  per pad {Z,Y,X,MODE,START,C,B,A,RIGHT,LEFT,DOWN,UP}, active-high, pad 0 in the low bits.
REQ-009 PAD_TYPE  input  NUM_PADS*2  per pad: 0=none, 1=3-button, 2=6-button, 3=none.
REQ-010 DATA  output  4  nibble presented on D3..D0, active-low button encoding.
REQ-011 TL  output  1  acknowledge line, echoes the last accepted TR level.

Function
REQ-012 State machine SHALL have states IDLE, HDR, TYPES, PADS and END.
REQ-013 IDLE (TH=1): DATA=4'h3, TL=1, nibble index=0.
REQ-014 TH sampled 1->0 SHALL snapshot PAD_BTN and PAD_TYPE, enter HDR with index 0, and set TL to the sampled TR.
REQ-015 Each sampled TR level change while TH=0 SHALL increment the index by one, and TL SHALL equal the new TR level with DATA valid from the same CE tick (1 CE tick latency from the TR edge).
REQ-016 HDR nibbles idx0..3 SHALL be 3,F,0,0; TYPES idx4..7 SHALL carry the type code per slot: 0 = 3-button, 1 = 6-button, F = none or slot >= NUM_PADS.
REQ-017 PADS SHALL emit, in slot order and skipping "none" slots, {R,L,D,U} then {S,A,C,B}, plus {M,X,Y,Z} for 6-button, each inverted.
REQ-018 After the final pad nibble the state SHALL be END with DATA=4'hF; further TR edges keep END, and the index saturates at its maximum (5 bits).
REQ-019 A sampled TH rise SHALL force IDLE on that tick and takes priority over a simultaneous TR edge.
REQ-020 Input changes after the TH fall SHALL NOT affect the sequence until the next TH fall.
REQ-021 With NUM_PADS=1 and pad type none, the sequence SHALL end (END) at idx8.

Reset
REQ-022 RESET_N low SHALL asynchronously force IDLE, index 0, DATA=4'h3, TL=1, watchdog 0, snapshots 0.
REQ-023 Reset asserted mid-sequence SHALL abort it; after release, a TH fall is required to start again.

Configuration
REQ-024 With TEAMPLAYER_WATCHDOG_EN defined, a counter SHALL clear on every TH/TR change and, on reaching TIMEOUT_CE while not in IDLE, force IDLE (DATA=3, TL=1) until TH next falls.
REQ-025 Without TEAMPLAYER_WATCHDOG_EN, no counter SHALL exist and the state persists indefinitely.

Structure
REQ-026 Package tp_pkg SHALL hold the state enum, pad-type enum, header constants (3,F,0,0), END nibble F and button-bit index constants.
REQ-027 Sub-module tp_nibble_sel SHALL map (snapshot, slot, nibble-within-pad) to DATA combinationally; teamplayer_n owns all sequential logic.

Verification
REQ-028 Reset, TH=1 -> DATA=3, TL=1.
REQ-029 NUM_PADS=4, types {3B,6B,none,3B}, pad0 A+UP pressed; TH fall, then 15 TR toggles -> 3,F,0,0,0,1,F,0, E,B, F,F,F, F,F, then END F.
REQ-030 TR toggle and TH rise in the same CE tick -> IDLE, DATA=3.
REQ-031 Pad0 buttons change after the TH fall -> the old snapshot is still emitted.
REQ-032 With the macro defined, TIMEOUT_CE=16, TH held low, no TR edges for 16 CE -> IDLE; without the macro -> still HDR.
REQ-033 RESET_N pulsed low at idx 9 -> DATA=3, TL=1 immediately; TR toggles ignored until a TH fall.
